// File: rtl/lcd_fb_writer.sv
// LCD pixel-stream receiver: tracks raster position, packs 4 x 2-bit pixels per byte, writes a linear framebuffer.
// Optional ping-pong buffering is enabled by defining LCD_FB_DOUBLE_BUF_EN.
module lcd_fb_writer #(
  parameter int H_PIXELS = 160,
  parameter int V_LINES  = 144,
  parameter int ADDR_W   = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lcd_vsync,
  input  logic              lcd_hsync,
  input  logic              lcd_pixel,
  input  logic [1:0]        lcd_color,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [7:0]        fb_data,
  output logic              fb_bank,
  output logic              front_bank,
  output logic              frame_done,
  output logic              err_short_line,
  output logic              err_stray_pixel,
  output logic              err_short_frame
);

  localparam int XW  = $clog2(H_PIXELS + 1);
  localparam int YW  = $clog2(V_LINES + 1);
  localparam int BPL = H_PIXELS / 4;

  typedef enum logic [1:0] {SYNC_WAIT, LINE_WAIT, ACTIVE} state_t;

  state_t              state_q, state_d;
  logic [XW-1:0]       x_q, x_d;
  logic [YW-1:0]       y_q, y_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   line_q, line_d;
  logic [5:0]          pack_q, pack_d;
  logic                vs_q, hs_q, vs_dly_q, hs_dly_q, pix_q;
  logic [1:0]          col_q;
  logic                we_q, we_d, done_q, done_d;
  logic                esl_q, esl_d, esp_q, esp_d, esf_q, esf_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [7:0]          wdata_q, wdata_d;
  logic                vs_edge, hs_edge;

  assign vs_edge = vs_q & ~vs_dly_q;
  assign hs_edge = hs_q & ~hs_dly_q;

  // Events are applied in order vsync, hsync, pixel so a coincident pixel lands in the new line.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    addr_d  = addr_q;
    line_d  = line_q;
    pack_d  = pack_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    esl_d   = 1'b0;
    esp_d   = 1'b0;
    esf_d   = 1'b0;

    if (vs_edge) begin
      if (state_d != SYNC_WAIT && (y_d != '0 || x_d != '0)) esf_d = 1'b1;
      state_d = LINE_WAIT;
      x_d     = '0;
      y_d     = '0;
      addr_d  = '0;
      line_d  = '0;
    end

    if (hs_edge) begin
      if (state_d == LINE_WAIT) begin
        state_d = ACTIVE;
        x_d     = '0;
      end else if (state_d == ACTIVE) begin
        esl_d  = 1'b1;
        line_d = line_d + ADDR_W'(BPL);
        addr_d = line_d;
        y_d    = y_d + YW'(1);
        x_d    = '0;
        if (y_d == YW'(V_LINES)) begin
          done_d  = 1'b1;
          state_d = SYNC_WAIT;
        end
      end
    end

    if (pix_q) begin
      if (state_d == ACTIVE) begin
        pack_d = {pack_d[3:0], col_q};
        if (x_d[1:0] == 2'd3) begin
          we_d    = 1'b1;
          waddr_d = addr_d;
          wdata_d = {pack_q, col_q};
          addr_d  = addr_d + ADDR_W'(1);
        end
        x_d = x_d + XW'(1);
        if (x_d == XW'(H_PIXELS)) begin
          x_d     = '0;
          y_d     = y_d + YW'(1);
          line_d  = addr_d;
          state_d = LINE_WAIT;
          if (y_d == YW'(V_LINES)) begin
            done_d  = 1'b1;
            state_d = SYNC_WAIT;
          end
        end
      end else begin
        esp_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vs_q     <= 1'b0;
      hs_q     <= 1'b0;
      vs_dly_q <= 1'b0;
      hs_dly_q <= 1'b0;
      pix_q    <= 1'b0;
      col_q    <= 2'd0;
      state_q  <= SYNC_WAIT;
      x_q      <= '0;
      y_q      <= '0;
      addr_q   <= '0;
      line_q   <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      done_q   <= 1'b0;
      esl_q    <= 1'b0;
      esp_q    <= 1'b0;
      esf_q    <= 1'b0;
    end else begin
      vs_q     <= lcd_vsync;
      hs_q     <= lcd_hsync;
      vs_dly_q <= vs_q;
      hs_dly_q <= hs_q;
      pix_q    <= lcd_pixel;
      col_q    <= lcd_color;
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      addr_q   <= addr_d;
      line_q   <= line_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      done_q   <= done_d;
      esl_q    <= esl_d;
      esp_q    <= esp_d;
      esf_q    <= esf_d;
    end
  end

  // Partial pixels need no reset: a byte is only written after four fresh shifts.
  always_ff @(posedge clk) begin
    pack_q <= pack_d;
  end

  assign fb_we           = we_q;
  assign fb_addr         = waddr_q;
  assign fb_data         = wdata_q;
  assign frame_done      = done_q;
  assign err_short_line  = esl_q;
  assign err_stray_pixel = esp_q;
  assign err_short_frame = esf_q;

`ifdef LCD_FB_DOUBLE_BUF_EN
  logic front_q, bank_q;

  // front flips the cycle after frame_done, so the final write of a frame still targets the back bank.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      front_q <= 1'b0;
      bank_q  <= 1'b0;
    end else begin
      if (done_q) front_q <= ~front_q;
      bank_q <= we_d & ~front_q;
    end
  end

  assign fb_bank    = bank_q;
  assign front_bank = front_q;
`else
  assign fb_bank    = 1'b0;
  assign front_bank = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_fb_writer.sv
// Randomized and directed bench for lcd_fb_writer against a raster-level reference model.
module tb_lcd_fb_writer;
  localparam int H = 160;
  localparam int V = 144;

  logic        clk, rst;
  logic        lcd_vsync, lcd_hsync, lcd_pixel;
  logic [1:0]  lcd_color;
  logic        fb_we, fb_bank, front_bank, frame_done;
  logic [12:0] fb_addr;
  logic [7:0]  fb_data;
  logic        err_short_line, err_stray_pixel, err_short_frame;

  lcd_fb_writer #(.H_PIXELS(H), .V_LINES(V), .ADDR_W(13)) dut (
    .clk(clk), .rst(rst),
    .lcd_vsync(lcd_vsync), .lcd_hsync(lcd_hsync), .lcd_pixel(lcd_pixel), .lcd_color(lcd_color),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data), .fb_bank(fb_bank), .front_bank(front_bank),
    .frame_done(frame_done), .err_short_line(err_short_line), .err_stray_pixel(err_stray_pixel),
    .err_short_frame(err_short_frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        we, done, esl, esp, esf, bank, front;
    logic [12:0] addr;
    logic [7:0]  data;
  } exp_t;

  int n_cmp, n_bad;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: raster bookkeeping with the address formula y*(H/4)+x/4.
  bit         m_framed, m_inline, m_pvs, m_phs, m_front;
  int         m_line, m_pcnt;
  logic [1:0] m_pix [4];
  exp_t       expq [$];

  task automatic model_reset();
    m_framed = 0; m_inline = 0; m_pvs = 0; m_phs = 0; m_front = 0;
    m_line = 0; m_pcnt = 0;
    expq.delete();
  endtask

  task automatic model_step(input logic vs, input logic hs, input logic px, input logic [1:0] col,
                            output exp_t e);
    bit vse, hse;
    vse = vs && !m_pvs;
    hse = hs && !m_phs;
    m_pvs = vs; m_phs = hs;
    e = '0;
    if (vse) begin
      if (m_framed && (m_line != 0 || m_pcnt != 0)) e.esf = 1'b1;
      m_framed = 1; m_inline = 0; m_line = 0; m_pcnt = 0;
    end
    if (hse && m_framed) begin
      if (m_inline) begin
        e.esl = 1'b1;
        m_line++; m_pcnt = 0;
        if (m_line == V) begin e.done = 1'b1; m_framed = 0; m_inline = 0; end
      end else begin
        m_inline = 1; m_pcnt = 0;
      end
    end
    if (px) begin
      if (m_framed && m_inline) begin
        m_pix[m_pcnt % 4] = col;
        m_pcnt++;
        if (m_pcnt % 4 == 0) begin
          e.we   = 1'b1;
          e.addr = 13'(m_line * (H / 4) + (m_pcnt - 1) / 4);
          e.data = {m_pix[0], m_pix[1], m_pix[2], m_pix[3]};
        end
        if (m_pcnt == H) begin
          m_line++; m_pcnt = 0; m_inline = 0;
          if (m_line == V) begin e.done = 1'b1; m_framed = 0; end
        end
      end else begin
        e.esp = 1'b1;
      end
    end
`ifdef LCD_FB_DOUBLE_BUF_EN
    e.front = m_front;
    e.bank  = e.we ? ~m_front : 1'b0;
    if (e.done) m_front = ~m_front;
`endif
  endtask

  function automatic logic [31:0] obs_of(input exp_t h);
    exp_t o;
    o.we = fb_we; o.done = frame_done; o.esl = err_short_line; o.esp = err_stray_pixel;
    o.esf = err_short_frame; o.bank = fb_bank; o.front = front_bank;
    o.addr = h.we ? fb_addr : 13'd0;
    o.data = h.we ? fb_data : 8'd0;
    return {4'd0, o};
  endfunction

  function automatic logic [31:0] all_outs();
    return {4'd0, fb_we, frame_done, err_short_line, err_stray_pixel, err_short_frame,
            fb_bank, front_bank, fb_addr, fb_data};
  endfunction

  // One input cycle; outputs caused by a cycle's inputs are compared two cycles later.
  task automatic tick(input logic vs, input logic hs, input logic px, input logic [1:0] col);
    exp_t e, h;
    @(negedge clk);
    if (expq.size() == 2) begin
      h = expq.pop_front();
      check("cycle", obs_of(h), {4'd0, h});
    end
    lcd_vsync = vs; lcd_hsync = hs; lcd_pixel = px; lcd_color = col;
    model_step(vs, hs, px, col, e);
    expq.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 2'd0);
    #1;
  endtask

  task automatic send_line(input int n, input bit rnd);
    for (int i = 0; i < n; i++) tick(0, i == 0, 1, rnd ? 2'($urandom_range(0, 3)) : 2'(i % 4));
    if (n == 0) tick(0, 1, 0, 2'd0);
    tick(0, 0, 0, 2'd0);
  endtask

  // Output event counters, sampled on the same edge as the per-cycle checks.
  int wcnt, dcnt, esl_cnt, esp_cnt, esf_cnt, bad1b;
  logic [12:0] last_waddr, done_addr;
  logic [7:0]  last_wdata;
  logic        done_we;
  initial begin
    wcnt = 0; dcnt = 0; esl_cnt = 0; esp_cnt = 0; esf_cnt = 0; bad1b = 0;
    last_waddr = '0; last_wdata = '0; done_addr = '0; done_we = 1'b0;
  end
  always @(negedge clk) begin
    if (rst) begin
      if (fb_we) begin
        wcnt++; last_waddr = fb_addr; last_wdata = fb_data;
        if (fb_data != 8'h1B) bad1b++;
      end
      if (frame_done) begin dcnt++; done_addr = fb_addr; done_we = fb_we; end
      if (err_short_line) esl_cnt++;
      if (err_stray_pixel) esp_cnt++;
      if (err_short_frame) esf_cnt++;
    end
  end

  int bw, bd, bl, bp, bf, bb;
  task automatic snap();
    bw = wcnt; bd = dcnt; bl = esl_cnt; bp = esp_cnt; bf = esf_cnt; bb = bad1b;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rst = 1'b0; lcd_vsync = 0; lcd_hsync = 0; lcd_pixel = 0; lcd_color = 2'd0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_outputs", all_outs(), 32'd0);
    rst = 1'b1;

    // Stray pixels and ignored hsync before the first vsync.
    snap();
    tick(0, 0, 1, 2'd1); tick(0, 0, 1, 2'd2); tick(0, 1, 1, 2'd3); idle(3);
    check("pre_vsync_stray", 32'(esp_cnt - bp), 32'd3);
    check("pre_vsync_writes", 32'(wcnt - bw), 32'd0);

    // Pixels 3,2,1,0 on line 0.
    snap();
    tick(1, 0, 0, 2'd0); tick(0, 0, 0, 2'd0); tick(0, 1, 0, 2'd0);
    tick(0, 0, 1, 2'd3); tick(0, 0, 1, 2'd2); tick(0, 0, 1, 2'd1); tick(0, 0, 1, 2'd0);
    idle(3);
    check("e4_writes", 32'(wcnt - bw), 32'd1);
    check("e4_addr", 32'(last_waddr), 32'd0);
    check("e4_data", 32'(last_wdata), 32'hE4);

    // Short line 5, stray pixels between lines, then vsync after 50 lines.
    tick(1, 0, 0, 2'd0); tick(0, 0, 0, 2'd0); idle(2);
    snap();
    for (int l = 0; l < 5; l++) send_line(160, 1);
    tick(0, 0, 1, 2'd0); tick(0, 0, 1, 2'd3); idle(3);
    check("between_line_stray", 32'(esp_cnt - bp), 32'd2);
    snap();
    send_line(10, 1); idle(1);
    check("short_line_writes", 32'(wcnt - bw), 32'd2);
    check("short_line_last_addr", 32'(last_waddr), 32'd201);
    send_line(160, 1); idle(1);
    check("short_line_err", 32'(esl_cnt - bl), 32'd1);
    check("line6_writes", 32'(wcnt - bw), 32'd42);
    check("line6_last_addr", 32'(last_waddr), 32'd279);
    for (int l = 7; l < 50; l++) send_line(160, 1);
    snap();
    tick(1, 0, 0, 2'd0); idle(3);
    check("short_frame_err", 32'(esf_cnt - bf), 32'd1);
    check("short_frame_no_done", 32'(dcnt - bd), 32'd0);
    check("short_frame_front", 32'(front_bank), 32'd0);

    // Restarted frame writes address 0, then reset mid-line while that write is visible.
    snap();
    for (int i = 0; i < 6; i++) tick(0, i == 0, 1, 2'(i % 4));
    #1;
    check("restart_first_addr", 32'(last_waddr), 32'd0);
    check("restart_writes", 32'(wcnt - bw), 32'd1);
    #1 rst = 1'b0;
    #1 check("midline_reset_outputs", all_outs(), 32'd0);
    model_reset();
    @(negedge clk);
    lcd_vsync = 0; lcd_hsync = 0; lcd_pixel = 0; lcd_color = 2'd0;
    rst = 1'b1;
    snap();
    tick(0, 0, 1, 2'd1); tick(0, 0, 1, 2'd1);
    for (int i = 0; i < 4; i++) tick(0, i == 0, 1, 2'd2);
    idle(3);
    check("post_reset_no_write", 32'(wcnt - bw), 32'd0);
    check("post_reset_stray", 32'(esp_cnt - bp), 32'd6);
    tick(1, 0, 0, 2'd0); tick(0, 0, 0, 2'd0);
    for (int i = 0; i < 4; i++) tick(0, i == 0, 1, 2'd2);
    idle(3);
    check("post_reset_first_write", 32'(wcnt - bw), 32'd1);

    // Two complete frames with color = x%4.
    for (int f = 0; f < 2; f++) begin
      tick(1, 0, 0, 2'd0); tick(0, 0, 0, 2'd0);
      snap();
      for (int l = 0; l < V; l++) send_line(H, 0);
      idle(3);
      check("frame_writes", 32'(wcnt - bw), 32'd5760);
      check("frame_data_1b", 32'(bad1b - bb), 32'd0);
      check("frame_done_count", 32'(dcnt - bd), 32'd1);
      check("frame_done_addr", 32'(done_addr), 32'd5759);
      check("frame_done_with_we", 32'(done_we), 32'd1);
`ifdef LCD_FB_DOUBLE_BUF_EN
      check("front_after_frame", 32'(front_bank), (f == 0) ? 32'd1 : 32'd0);
`else
      check("front_after_frame", 32'(front_bank), 32'd0);
`endif
    end

    // Random lines of near-nominal length with random gaps, then fully random traffic.
    tick(1, 0, 0, 2'd0);
    for (int l = 0; l < 30; l++) begin
      if ($urandom_range(0, 9) == 0) tick(1, 0, 0, 2'd0);
      send_line($urandom_range(150, 165), 1);
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) tick(0, 0, $urandom_range(0, 1) == 1, 2'd1);
    end
    for (int i = 0; i < 6000; i++)
      tick($urandom_range(0, 299) == 0, $urandom_range(0, 29) == 0,
           $urandom_range(0, 4) != 0, 2'($urandom_range(0, 3)));
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/lcd_fb_writer.md
# lcd_fb_writer

Receiving end of the PPU LCD pixel stream. Consumes `lcd_vsync`/`lcd_hsync`/`lcd_pixel`/`lcd_color` exactly as `ppu_m` drives them, tracks raster position, packs four 2-bit pixels per byte and writes a linear framebuffer through a single write port. Sits beside `ppu_m` in the DMG top, on the same clock, feeding the video-out / host-readback framebuffer RAM.

## Interface
- `H_PIXELS`, 160, active pixels per line; must be a multiple of 4
- `V_LINES`, 144, active lines per frame
- `ADDR_W`, 13, framebuffer byte-address width; must satisfy H_PIXELS*V_LINES/4 ≤ 2^ADDR_W
- `clk` in 1: system clock, same as `ppu_m`
- `rst` in 1: asynchronous, active-low reset
- `lcd_vsync` in 1: frame sync; a rising edge starts a frame
- `lcd_hsync` in 1: line sync; a rising edge starts a line
- `lcd_pixel` in 1: one-cycle strobe qualifying `lcd_color`
- `lcd_color` in 2: pixel shade, 0 = lightest
- `fb_we` out 1: framebuffer write strobe, one cycle per byte
- `fb_addr` out ADDR_W: byte address, y*(H_PIXELS/4) + x/4
- `fb_data` out 8: packed byte; pixel x%4==0 in [7:6], x%4==3 in [1:0]
- `fb_bank` out 1: bank being written (double-buffer only, else 0)
- `front_bank` out 1: bank holding the last complete frame (else 0)
- `frame_done` out 1: one-cycle pulse after the last byte of a complete frame
- `err_short_line` out 1: one-cycle pulse, line ended early
- `err_stray_pixel` out 1: one-cycle pulse, pixel outside an active line
- `err_short_frame` out 1: one-cycle pulse, vsync before V_LINES lines

## Operation
- Sync inputs registered once; edges detected against registered copies. Pixel path uses the same registered copies so pixel/sync order is preserved.
- State SYNC_WAIT (reset state): ignore hsync. Pixels → `err_stray_pixel`. vsync edge → LINE_WAIT, y=0, address counter=0.
- LINE_WAIT: hsync edge → ACTIVE, x=0. Pixel → `err_stray_pixel`, ignored.
- ACTIVE: each pixel shifts color into the pack register, x++. On x%4==3, the byte is written with `fb_addr` from a running counter, and the counter is incremented; no multiplier. When x reaches H_PIXELS: y++. If y==V_LINES, pulse `frame_done` and go to SYNC_WAIT; otherwise go to LINE_WAIT.
- hsync edge in ACTIVE with x<H_PIXELS: pulse `err_short_line`. Discard the partial byte. Advance the address counter to the next line start. y++. Stay ACTIVE with x=0 (the edge starts the new line). If y reaches V_LINES as a result, treat it as frame end (pulse `frame_done`, go to SYNC_WAIT).
- vsync edge in LINE_WAIT or ACTIVE: if y≠0 or x≠0, pulse `err_short_frame`. Restart with y=0, counter=0, state LINE_WAIT. No `frame_done`.
- Simultaneous vsync and hsync edges: vsync is processed first, then hsync. Result: LINE_WAIT→ACTIVE in the same cycle, frame restarted, line 0 active.
- Pixel in the same cycle as an hsync edge belongs to the new line.

## Timing
- Pixels are accepted back-to-back, every cycle. Throughput is one pixel per clock.
- Latency: `fb_we` is high two cycles after the fourth `lcd_pixel` of a byte (one cycle for the input register, one for the output register). `fb_addr`/`fb_data` are valid only while `fb_we` is high.
- `frame_done` is asserted in the same cycle as the final `fb_we`.
- Error pulses are asserted two cycles after the offending input.
- Reset values: all outputs 0; state SYNC_WAIT; x=y=0; counter 0. Reset mid-frame drops any pending byte; no write follows.

## Configuration
- `LCD_FB_DOUBLE_BUF_EN` defined: ping-pong buffering.
  - Writes target `fb_bank` = ~`front_bank`.
  - `front_bank` toggles in the cycle after `frame_done`.
  - Short or aborted frames never swap banks.
  - The external RAM decodes {`fb_bank`, `fb_addr`}.
- Not defined: `fb_bank` = `front_bank` = 0 constant; single buffer.

## Test plan
- Full frame: vsync, then 144 hsyncs each followed by 160 pixels with color=x%4. Expect 5760 writes, data 0x1B at every address 0..5759, and exactly one `frame_done`, coincident with the addr-5759 write.
- Back-to-back pixels 3,2,1,0 on line 0 → single write, addr 0, data 0xE4, two cycles after the 4th strobe.
- Line 5 ends after 10 pixels → `err_short_line` once. Writes to 200,201 only; pixels 8,9 dropped. Line 6 starts at addr 240.
- Pixels before the first vsync and between lines → `err_stray_pixel` per pixel, no `fb_we`.
- vsync after 50 lines → `err_short_frame`, no `frame_done`. The next write is addr 0. With `LCD_FB_DOUBLE_BUF_EN`: `front_bank` unchanged here; after two complete frames it has toggled twice.
- `rst` low mid-line after 2 pixels → all outputs 0 immediately. No write after release until vsync + hsync + 4 pixels.
